apb_slave_regfile: RTL and testbench

- APB slave with a register bank; sits directly downstream of apb_master and consumes its psel/penable/pwrite/paddr/pwdata.
- Returns prdata/pready/pslverr to the master.
- Inserts a programmable number of wait states per transfer and flags out-of-range addresses with pslverr.
- Exposes the register contents and a write strobe to local logic.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_slave_regfile_if.sv | 31 +++
 rtl/apb_regbank.sv | 59 +++++
 rtl/apb_slave_regfile.sv | 160 ++++++++++++++++
 tb/tb_apb_slave_regfile.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding and bus width defaults
// Contents: apb_state_e (IDLE/WAIT/RESP, common to apb_master and slaves),
//           APB_ADDR_W / APB_DATA_W default widths.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// rtl/apb_slave_regfile_if.sv - APB bus bundle between master and slave
// Signals: psel, penable, pwrite, paddr, pwdata (master -> slave);
//          prdata, pready, pslverr (slave -> master).
// Modports: master, slave.
interface apb_slave_regfile_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_regbank.sv
// rtl/apb_regbank.sv - NUM_REGS x DATA_W register storage
// Ports: clk, reset (async, active-high); write port we/wr_idx/wdata;
//        combinational read port rd_idx -> rdata (0 for out-of-range index);
//        reg_q flattened contents, reg i at [i*DATA_W +: DATA_W].
module apb_regbank #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            wr_idx,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [ADDR_W-1:0]            rd_idx,
    output logic [DATA_W-1:0]            rdata,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Index decode by comparison so the address width never has to match
    // the array depth.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we && (wr_idx == ADDR_W'(i))) begin
                regs_d[i] = wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == ADDR_W'(i)) begin
                rdata = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB slave with wait states, range check and register bank
// Ports: clk, reset (async, active-high); bus (apb_slave_regfile_if.slave);
//        reg_q flattened register contents; wr_pulse one cycle after a
//        committed write; wr_idx index of the last committed write.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    apb_slave_regfile_if.slave         bus,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_idx
);

    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;

    logic              we;
    logic [DATA_W-1:0] rdata;
    logic              setup;

    assign setup = bus.psel && !bus.penable;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        we         = 1'b0;
        wr_idx_d   = wr_idx_q;

        case (state_q)
            IDLE: begin
                if (setup) begin
                    addr_d  = bus.paddr;
                    write_d = bus.pwrite;
                    wdata_d = bus.pwdata;
                    err_d   = ({1'b0, bus.paddr} >= LIMIT);
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (!bus.penable) begin
                    // A fresh setup mid-wait restarts the transfer.
                    addr_d  = bus.paddr;
                    write_d = bus.pwrite;
                    wdata_d = bus.pwdata;
                    err_d   = ({1'b0, bus.paddr} >= LIMIT);
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                // The write only lands if the master is still holding the
                // ACCESS phase when the response completes.
                we      = bus.psel && bus.penable && write_q && !err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_pulse_d = we;
        if (we) begin
            wr_idx_d = addr_q;
        end
    end

    // Response registers are loaded on the edge entering RESP, so they look
    // at the next-state values; the read index is addr_d so a zero-wait read
    // sees paddr directly from the setup cycle.
    always_comb begin
        pready_d  = (state_d == RESP);
        pslverr_d = (state_d == RESP) && err_d;
        prdata_d  = '0;
        if ((state_d == RESP) && !write_d && !err_d) begin
            prdata_d = rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
        end
    end

    apb_regbank #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regbank (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .wr_idx (addr_q),
        .wdata  (wdata_q),
        .rd_idx (addr_d),
        .rdata  (rdata),
        .reg_q  (reg_q)
    );

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign wr_pulse    = wr_pulse_q;
    assign wr_idx      = wr_idx_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed bench for apb_slave_regfile (2 and 0 wait states)
module tb_apb_slave_regfile;

    logic clk;
    logic reset;

    logic [127:0] rq_a, rq_b;
    logic         wp_a, wp_b;
    logic [7:0]   wi_a, wi_b;
    logic [127:0] exp_regs;

    int checks = 0;
    int errors = 0;

    apb_slave_regfile_if #(.ADDR_W(8), .DATA_W(8)) ifa ();
    apb_slave_regfile_if #(.ADDR_W(8), .DATA_W(8)) ifb ();

    apb_slave_regfile #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(16), .WAIT_CYCLES(2)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .bus      (ifa),
        .reg_q    (rq_a),
        .wr_pulse (wp_a),
        .wr_idx   (wi_a)
    );

    apb_slave_regfile #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(16), .WAIT_CYCLES(0)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .bus      (ifb),
        .reg_q    (rq_b),
        .wr_pulse (wp_b),
        .wr_idx   (wi_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_a();
        ifa.psel = 1'b0; ifa.penable = 1'b0; ifa.pwrite = 1'b0;
        ifa.paddr = 8'h00; ifa.pwdata = 8'h00;
    endtask

    // Full 2-wait-state transfer on dut_a with checks on every cycle.
    task automatic xfer_a(input string tag, input bit wr, input logic [7:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd, input bit exp_err);
        ifa.psel = 1'b1; ifa.penable = 1'b0; ifa.pwrite = wr;
        ifa.paddr = addr; ifa.pwdata = wd;
        tick();
        ifa.penable = 1'b1;
        check({tag, " acc1 pready"}, ifa.pready, 1'b0);
        check({tag, " acc1 prdata"}, ifa.prdata, 8'h00);
        tick();
        check({tag, " acc2 pready"}, ifa.pready, 1'b0);
        check({tag, " acc2 prdata"}, ifa.prdata, 8'h00);
        tick();
        check({tag, " acc3 pready"}, ifa.pready, 1'b1);
        check({tag, " acc3 pslverr"}, ifa.pslverr, exp_err);
        check({tag, " acc3 prdata"}, ifa.prdata, exp_rd);
        tick();
        idle_a();
        check({tag, " post pready"}, ifa.pready, 1'b0);
        check({tag, " post prdata"}, ifa.prdata, 8'h00);
        check({tag, " post wr_pulse"}, wp_a, wr && !exp_err);
        if (wr && !exp_err) begin
            exp_regs[addr*8 +: 8] = wd;
            check({tag, " post wr_idx"}, wi_a, addr);
        end
        check({tag, " post reg_q"}, rq_a, exp_regs);
        tick();
        check({tag, " pulse clears"}, wp_a, 1'b0);
    endtask

    initial begin
        exp_regs = '0;
        idle_a();
        ifb.psel = 1'b0; ifb.penable = 1'b0; ifb.pwrite = 1'b0;
        ifb.paddr = 8'h00; ifb.pwdata = 8'h00;
        reset = 1'b1;
        tick();
        tick();
        check("reset pready", ifa.pready, 1'b0);
        check("reset pslverr", ifa.pslverr, 1'b0);
        check("reset prdata", ifa.prdata, 8'h00);
        check("reset wr_pulse", wp_a, 1'b0);
        check("reset wr_idx", wi_a, 8'h00);
        check("reset reg_q", rq_a, 128'h0);
        reset = 1'b0;
        tick();

        xfer_a("wr a5@03", 1'b1, 8'h03, 8'hA5, 8'h00, 1'b0);
        xfer_a("rd 03", 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0);
        xfer_a("wr 77@10 err", 1'b1, 8'h10, 8'h77, 8'h00, 1'b1);
        xfer_a("rd 20 err", 1'b0, 8'h20, 8'h00, 8'h00, 1'b1);
        xfer_a("rd 0f edge", 1'b0, 8'h0F, 8'h00, 8'h00, 1'b0);

        // Zero wait states, back-to-back write then read as apb_master drives it.
        ifb.psel = 1'b1; ifb.penable = 1'b0; ifb.pwrite = 1'b1;
        ifb.paddr = 8'h00; ifb.pwdata = 8'h11;
        tick();
        ifb.penable = 1'b1;
        check("b2b wr pready", ifb.pready, 1'b1);
        check("b2b wr pslverr", ifb.pslverr, 1'b0);
        tick();
        ifb.penable = 1'b0; ifb.pwrite = 1'b0; ifb.pwdata = 8'h00;
        check("b2b rd setup pready", ifb.pready, 1'b0);
        check("b2b wr_pulse", wp_b, 1'b1);
        check("b2b wr_idx", wi_b, 8'h00);
        check("b2b reg_q", rq_b, 128'h11);
        tick();
        ifb.penable = 1'b1;
        check("b2b rd pready", ifb.pready, 1'b1);
        check("b2b rd prdata", ifb.prdata, 8'h11);
        tick();
        ifb.psel = 1'b0; ifb.penable = 1'b0;
        check("b2b end pready", ifb.pready, 1'b0);
        check("b2b end prdata", ifb.prdata, 8'h00);
        check("b2b rd no pulse", wp_b, 1'b0);

        // Abort: psel drops during WAIT of a write of 0x5A to 0x02.
        ifa.psel = 1'b1; ifa.penable = 1'b0; ifa.pwrite = 1'b1;
        ifa.paddr = 8'h02; ifa.pwdata = 8'h5A;
        tick();
        ifa.penable = 1'b1;
        tick();
        idle_a();
        tick();
        check("abort pready", ifa.pready, 1'b0);
        tick();
        check("abort pready2", ifa.pready, 1'b0);
        check("abort wr_pulse", wp_a, 1'b0);
        check("abort reg_q", rq_a, exp_regs);
        tick();
        check("abort wr_pulse2", wp_a, 1'b0);
        xfer_a("rd 02 after abort", 1'b0, 8'h02, 8'h00, 8'h00, 1'b0);

        // Reset during WAIT of a write.
        ifa.psel = 1'b1; ifa.penable = 1'b0; ifa.pwrite = 1'b1;
        ifa.paddr = 8'h05; ifa.pwdata = 8'h3C;
        tick();
        ifa.penable = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        check("rst mid pready", ifa.pready, 1'b0);
        check("rst mid wr_idx", wi_a, 8'h00);
        check("rst mid reg_q", rq_a, 128'h0);
        check("rst mid wr_pulse", wp_a, 1'b0);
        idle_a();
        tick();
        reset = 1'b0;
        exp_regs = '0;
        tick();
        check("rst no write", rq_a, 128'h0);
        xfer_a("wr 3c@05 after rst", 1'b1, 8'h05, 8'h3C, 8'h00, 1'b0);
        xfer_a("rd 05 after rst", 1'b0, 8'h05, 8'h00, 8'h3C, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
